byte_lane_arbiter: RTL

//   Round-robin scheduler that shares one 8-bit PHY byte path between two requesting lanes.

---
 rtl/byte_lane_arbiter_if.sv | 31 +++
 rtl/byte_lane_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/byte_lane_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : byte_lane_arbiter_if
// Brief    : Two ingress byte streams and one egress byte stream, valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
interface byte_lane_arbiter_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in0_data;
    logic              in0_valid;
    logic              in0_ready;
    logic [DATA_W-1:0] in1_data;
    logic              in1_valid;
    logic              in1_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_src;
    logic              out_ready;

    modport master (
        output in0_data, in0_valid, in1_data, in1_valid, out_ready,
        input  in0_ready, in1_ready, out_data, out_valid, out_src
    );

    modport slave (
        input  in0_data, in0_valid, in1_data, in1_valid, out_ready,
        output in0_ready, in1_ready, out_data, out_valid, out_src
    );
endinterface
`default_nettype wire

// File: rtl/byte_lane_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : byte_lane_arbiter
// Brief    : Round-robin arbiter sharing one registered byte path between two
//            FIFO-buffered lanes, with a per-grant burst limit.
// Revision : 1.0 - initial release
// ============================================================================
module byte_lane_arbiter #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_BURST  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         lane_en,
    output logic               busy,
    byte_lane_arbiter_if.slave bus
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL      = c_CW'(FIFO_DEPTH);
    localparam logic [3:0]      c_MAX_BURST = 4'(MAX_BURST);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SERVE0 = 2'd1;
    localparam logic [1:0] c_SERVE1 = 2'd2;

    logic [DATA_W-1:0] w_in_data [2];
    logic [DATA_W-1:0] w_head    [2];
    logic [1:0]        w_in_valid;
    logic [1:0]        w_in_ready;
    logic [1:0]        w_push;
    logic [1:0]        w_pop;
    logic [1:0]        w_empty;
    logic [1:0]        w_full;
    logic [1:0]        w_elig;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [3:0]        r_burst_cnt;
    logic              r_last;
    logic              w_cur;
    logic              w_grant;
    logic              w_grant_lane;
    logic              w_load_en;

    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_out_src;

    assign w_in_data[0]  = bus.in0_data;
    assign w_in_data[1]  = bus.in1_data;
    assign w_in_valid    = {bus.in1_valid, bus.in0_valid};
    assign bus.in0_ready = w_in_ready[0];
    assign bus.in1_ready = w_in_ready[1];

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
        logic [c_AW-1:0]   r_wr_ptr;
        logic [c_AW-1:0]   r_rd_ptr;
        logic [c_CW-1:0]   r_count;

        // Storage is not reset; the count alone decides what is valid.
        always_ff @(posedge clk) begin
            if (w_push[gi]) begin
                r_mem[r_wr_ptr] <= w_in_data[gi];
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push[gi]) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop[gi])  r_rd_ptr <= r_rd_ptr + 1'b1;
                case ({w_push[gi], w_pop[gi]})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: ;
                endcase
            end
        end

        assign w_empty[gi]    = (r_count == '0);
        assign w_full[gi]     = (r_count == c_FULL);
        assign w_head[gi]     = r_mem[r_rd_ptr];
        // Ready comes only from registered occupancy, never from out_ready.
        assign w_in_ready[gi] = reset && !w_full[gi];
        assign w_push[gi]     = w_in_valid[gi] && w_in_ready[gi];
    end

    assign w_elig    = lane_en & ~w_empty;
    assign w_load_en = !r_out_valid || bus.out_ready;
    assign w_cur     = (r_state == c_SERVE1);

    // State register, burst counter and last-served lane.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_IDLE;
            r_burst_cnt <= '0;
            r_last      <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_en) begin
                if (!w_grant) begin
                    r_burst_cnt <= '0;
                end else begin
                    r_last <= w_grant_lane;
                    if (r_state != c_IDLE && w_grant_lane == w_cur) begin
                        if (r_burst_cnt < c_MAX_BURST) r_burst_cnt <= r_burst_cnt + 1'b1;
                    end else begin
                        r_burst_cnt <= 4'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_load_en) begin
            if (!w_grant)         w_state_nxt = c_IDLE;
            else if (w_grant_lane) w_state_nxt = c_SERVE1;
            else                  w_state_nxt = c_SERVE0;
        end
    end

    always_comb begin
        w_grant      = 1'b0;
        w_grant_lane = 1'b0;
        case (r_state)
            c_SERVE0, c_SERVE1: begin
                if (w_elig[w_cur] && (r_burst_cnt < c_MAX_BURST || !w_elig[~w_cur])) begin
                    w_grant      = 1'b1;
                    w_grant_lane = w_cur;
                end else if (w_elig[~w_cur]) begin
                    w_grant      = 1'b1;
                    w_grant_lane = ~w_cur;
                end
            end
            default: begin
                if (&w_elig) begin
                    w_grant      = 1'b1;
                    w_grant_lane = ~r_last;
                end else if (|w_elig) begin
                    w_grant      = 1'b1;
                    w_grant_lane = w_elig[1];
                end
            end
        endcase
        w_pop = 2'b00;
        if (w_load_en && w_grant) w_pop[w_grant_lane] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= 1'b0;
        end else if (w_load_en) begin
            r_out_valid <= w_grant;
            if (w_grant) begin
                r_out_data <= w_head[w_grant_lane];
                r_out_src  <= w_grant_lane;
            end
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_src   = r_out_src;
    assign busy          = r_out_valid || (w_empty != 2'b11);

endmodule
`default_nettype wire
